// File: rtl/uart_imem_loader.sv
// UART (8N1) boot loader: receives an A5/length/data/checksum image and writes it
// word-by-word into instruction memory, holding the CPU in reset while loading.
module uart_imem_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0]      Header   = 8'hA5;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       rx_state_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            stop_tick, byte_valid, frame_err;
  logic [7:0]      rx_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Start is edge-triggered so a line still low after a bad stop bit cannot
  // re-trigger a frame on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxData: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxStop: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  always_comb begin
    stop_tick  = (rx_state_q == RxStop) && (rx_cnt_q == BitLast);
    byte_valid = stop_tick && rx_sync_q;
    frame_err  = stop_tick && !rx_sync_q;
    rx_byte    = rx_shift_q;
  end

  // ---------------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    LdIdle, LdLenLo, LdLenHi, LdData, LdChk, LdDone, LdErr
  } ld_state_e;

  ld_state_e       ld_state_q;
  logic [7:0]      len_lo_q;
  logic [ADDR_W:0] n_words_q;
  logic [ADDR_W:0] word_idx_q;
  logic [1:0]      byte_cnt_q;
  logic [31:0]     asm_q;
  logic [7:0]      csum_q;

  logic [15:0]     len_full;
  logic            len_ok;
  logic [31:0]     asm_next;
  logic [ADDR_W:0] word_idx_next;
  logic            restartable;

  always_comb begin
    len_full      = {rx_byte, len_lo_q};
    len_ok        = (len_full != 16'd0) && (32'(len_full) <= 32'(MaxWords));
    asm_next      = {rx_byte, asm_q[31:8]};
    word_idx_next = word_idx_q + 1'b1;
    restartable   = (ld_state_q == LdIdle) || (ld_state_q == LdDone) ||
                    (ld_state_q == LdErr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q <= LdIdle;
      len_lo_q   <= '0;
      n_words_q  <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      im_we      <= 1'b0;
      im_waddr   <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (frame_err) begin
        // Outside a load a bad frame is only flagged; inside one it aborts.
        err <= 1'b1;
        if ((ld_state_q != LdIdle) && (ld_state_q != LdDone)) ld_state_q <= LdErr;
      end else if (byte_valid) begin
        if (restartable && (rx_byte == Header)) begin
          ld_state_q <= LdLenLo;
          cpu_hold   <= 1'b1;
          done       <= 1'b0;
          err        <= 1'b0;
          word_idx_q <= '0;
          byte_cnt_q <= '0;
          csum_q     <= '0;
        end else begin
          case (ld_state_q)
            LdLenLo: begin
              len_lo_q   <= rx_byte;
              ld_state_q <= LdLenHi;
            end
            LdLenHi: begin
              if (len_ok) begin
                n_words_q  <= len_full[ADDR_W:0];
                ld_state_q <= LdData;
              end else begin
                err        <= 1'b1;
                ld_state_q <= LdErr;
              end
            end
            LdData: begin
              asm_q      <= asm_next;
              csum_q     <= csum_q ^ rx_byte;
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                im_we      <= 1'b1;
                im_waddr   <= word_idx_q[ADDR_W-1:0];
                im_wdata   <= asm_next;
                word_idx_q <= word_idx_next;
                if (word_idx_next == n_words_q) ld_state_q <= LdChk;
              end
            end
            LdChk: begin
              if (rx_byte == csum_q) begin
                done       <= 1'b1;
                cpu_hold   <= 1'b0;
                ld_state_q <= LdDone;
              end else begin
                err        <= 1'b1;
                ld_state_q <= LdErr;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized self-checking bench for uart_imem_loader; expected writes and flags
// are derived from the packet contents the bench itself builds.
module tb_uart_imem_loader;

  localparam int unsigned CPB = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned MAX = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic          cpu_hold, done, err;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .im_we    (im_we),
    .im_waddr (im_waddr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned         n_checks = 0;
  int unsigned         n_pass = 0;
  logic [AW+31:0]      got_q[$];
  logic [AW+31:0]      exp_q[$];
  logic [31:0]         words_q[$];

  always @(negedge clk) if (rst_n && im_we) got_q.push_back({im_waddr, im_wdata});

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge so bytes can run back-to-back.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    if (!stop_bit) drive_bit(1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends A5, length n, the words in words_q and the XOR checksum ^ chk_xor.
  task automatic send_packet(input logic [15:0] n, input logic [7:0] chk_xor, input bit gaps);
    logic [7:0] sum;
    logic [7:0] b;
    logic [31:0] w;
    got_q.delete();
    exp_q.delete();
    sum = 8'h00;
    send_byte(8'hA5);
    check_eq("hold_after_hdr", 64'(cpu_hold), 64'd1);
    check_eq("done_clr_after_hdr", 64'(done), 64'd0);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < words_q.size(); i++) begin
      w = words_q[i];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        sum ^= b;
        send_byte(b);
        if (gaps) idle($urandom_range(0, 2 * CPB));
      end
      if (n >= 16'd1 && n <= 16'(MAX)) exp_q.push_back({AW'(i), w});
    end
    if (words_q.size() != 0) send_byte(sum ^ chk_xor);
    idle(4);
  endtask

  task automatic check_writes(input string tag);
    check_eq({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_wr%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic h);
    check_eq({tag, "_done"}, 64'(done), 64'(d));
    check_eq({tag, "_err"}, 64'(err), 64'(e));
    check_eq({tag, "_hold"}, 64'(cpu_hold), 64'(h));
  endtask

  task automatic rand_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values and an asynchronous reset arriving mid-frame.
    repeat (3) @(negedge clk);
    check_eq("rst_we", 64'(im_we), 64'd0);
    check_eq("rst_addr", 64'(im_waddr), 64'd0);
    check_eq("rst_data", 64'(im_wdata), 64'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(5);
    send_byte(8'hA5);
    check_eq("hold_pre_abort", 64'(cpu_hold), 64'd1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_flags("async_rst", 1'b0, 1'b0, 1'b0);
    check_eq("async_rst_we", 64'(im_we), 64'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    got_q.delete();
    rst_n = 1'b1;
    idle(50);
    check_eq("post_rst_nwr", 64'(got_q.size()), 64'd0);
    check_flags("post_rst", 1'b0, 1'b0, 1'b0);

    // Directed two-word image, good then bad checksum.
    words_q.delete();
    words_q.push_back(32'h12345678);
    words_q.push_back(32'hDEADBEEF);
    send_packet(16'd2, 8'h00, 1'b0);
    check_writes("good");
    check_flags("good", 1'b1, 1'b0, 1'b0);
    check_eq("good_addr_held", 64'(im_waddr), 64'd1);
    check_eq("good_data_held", 64'(im_wdata), 64'hDEADBEEF);
    send_packet(16'd2, 8'h2A ^ 8'h00 ^ 8'h2A ^ 8'h5F, 1'b0);
    check_writes("badchk");
    check_flags("badchk", 1'b0, 1'b1, 1'b1);

    // Length bounds.
    words_q.delete();
    send_packet(16'd0, 8'h00, 1'b0);
    check_writes("len0");
    check_flags("len0", 1'b0, 1'b1, 1'b1);
    send_packet(16'(MAX + 1), 8'h00, 1'b0);
    check_writes("lenmax1");
    check_flags("lenmax1", 1'b0, 1'b1, 1'b1);
    send_packet(16'h0801, 8'h00, 1'b0);
    check_writes("len801");
    check_flags("len801", 1'b0, 1'b1, 1'b1);
    rand_words(MAX);
    send_packet(16'(MAX), 8'h00, 1'b0);
    check_writes("lenmax");
    check_flags("lenmax", 1'b1, 1'b0, 1'b0);
    check_eq("lenmax_last_addr", 64'(im_waddr), 64'(MAX - 1));

    // Framing error on the second data byte aborts the load.
    got_q.delete();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    idle(4);
    check_eq("frame_nwr", 64'(got_q.size()), 64'd0);
    check_flags("frame", 1'b0, 1'b1, 1'b1);

    // Noise before the header, then a reload of a one-word image.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check_flags("noise_in_err", 1'b0, 1'b1, 1'b1);
    rand_words(3);
    send_packet(16'd3, 8'h00, 1'b1);
    check_writes("noise");
    check_flags("noise", 1'b1, 1'b0, 1'b0);
    rand_words(1);
    send_packet(16'd1, 8'h00, 1'b0);
    check_writes("reload");
    check_flags("reload", 1'b1, 1'b0, 1'b0);

    // Short low glitch while idle: no byte, nothing changes.
    got_q.delete();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(3 * CPB);
    check_eq("glitch_nwr", 64'(got_q.size()), 64'd0);
    check_flags("glitch", 1'b1, 1'b0, 1'b0);

    // Framing error while done only raises err.
    send_byte(8'h3C, 1'b0);
    idle(4);
    check_flags("frame_done", 1'b1, 1'b1, 1'b0);

    // Randomized images.
    for (int it = 0; it < 6; it++) begin
      bit bad;
      int n;
      n   = $urandom_range(1, 5);
      bad = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 8'hA4)));
      rand_words(n);
      send_packet(16'(n), bad ? 8'($urandom_range(1, 255)) : 8'h00, 1'($urandom_range(0, 1)));
      check_writes($sformatf("rnd%0d", it));
      check_flags($sformatf("rnd%0d", it), !bad, bad, bad);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
